multicycle_ctrl: RTL

//  Moore-style FSM that sequences the shared MIPS datapath multicycle: one ALU, one unified memory, IR/PC regs.

---
 rtl/mc_ctrl_pkg.sv | 41 ++++
 rtl/mc_ctrl_decode.sv | 69 ++++++
 rtl/multicycle_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, opcodes, mux codes and control word for the multicycle controller
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB
    } state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2;
    localparam logic [1:0] SRC_B_REG = 2'b00, SRC_B_FOUR = 2'b01, SRC_B_IMM = 2'b10, SRC_B_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10;
    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       instr_done;
    } ctrl_t;
    function automatic state_t dec_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEMADR;
            OP_R:         return S_EXEC;
            OP_BEQ:       return S_BRANCH;
            OP_J:         return S_JUMP;
            OP_ADDI:      return S_ADDIEX;
            default:      return S_FETCH;
        endcase
    endfunction
    function automatic logic legal_op(input logic [5:0] op);
        return dec_next(op) != S_FETCH;
    endfunction
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: Moore control word from current state, with the ready/zero qualified strobes
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   zero,
    input  logic   mem_ready,
    output ctrl_t  c
);
    always_comb begin
        c = '0;
        case (state)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.mem_read = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
                c.ir_write = mem_ready;
                c.pc_en = mem_ready;
            end
            S_DECODE: c.alu_src_b = SRC_B_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.mem_read = 1'b1;
                c.iord = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_write = 1'b1;
                c.iord = 1'b1;
                c.instr_done = mem_ready;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op = ALU_SUB;
                c.pc_src = PC_ALUOUT;
                c.pc_en = zero;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_src = PC_JUMP;
                c.pc_en = 1'b1;
                c.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS sequencer; MC_PERF_CNT_EN adds cycle_cnt/instr_cnt counters
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 4
`ifdef MC_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_src,
    output logic                pc_en,
    output logic                instr_done,
    output logic                illegal_op
`ifdef MC_PERF_CNT_EN
    , output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
`endif
);
    state_t state;
    ctrl_t  c, cg;
    mc_ctrl_decode u_decode (.state(state), .zero(zero), .mem_ready(mem_ready), .c(c));
    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else begin
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: state <= dec_next(opcode);
                S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state <= S_FETCH;
                S_EXEC:   state <= S_ALUWB;
                S_ADDIEX: state <= S_ADDIWB;
                default:  state <= S_FETCH;
            endcase
        end
    end
    // Outputs forced quiet during reset so no memory traffic leaks out
    assign cg = reset ? c : '0;
    assign mem_req = cg.mem_req;
    assign mem_read = cg.mem_read;
    assign mem_write = cg.mem_write;
    assign iord = cg.iord;
    assign ir_write = cg.ir_write;
    assign reg_dst = cg.reg_dst;
    assign mem_to_reg = cg.mem_to_reg;
    assign reg_write = cg.reg_write;
    assign alu_src_a = cg.alu_src_a;
    assign alu_src_b = cg.alu_src_b;
    assign alu_op = ALU_OP_W'(cg.alu_op);
    assign pc_src = cg.pc_src;
    assign pc_en = cg.pc_en;
    assign instr_done = cg.instr_done;
    assign illegal_op = reset && state == S_DECODE && !legal_op(opcode);
`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            instr_cnt <= instr_cnt + CNT_W'(instr_done);
        end
    end
`endif
endmodule
